// File: rtl/cmd_pkg.sv
// SPI upload command set: opcodes, decoder states and per-opcode framing lengths.
package cmd_pkg;

    typedef enum logic [3:0] {
        OP_WIPE        = 4'h0,
        OP_VERT        = 4'h1,
        OP_TRI         = 4'h2,
        OP_CREATE_INST = 4'h3,
        OP_UPDATE_INST = 4'h4,
        OP_DONE        = 4'h5
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } dec_state_e;

    localparam logic [7:0] OP_MAX = 8'h05;

    localparam logic [5:0] VERT_HDR_BYTES   = 6'd4;
    localparam logic [5:0] TRI_HDR_BYTES    = 6'd4;
    localparam logic [5:0] CREATE_HDR_BYTES = 6'd3;
    localparam logic [5:0] UPDATE_HDR_BYTES = 6'd1;

    localparam logic [5:0] VERT_REC_BYTES   = 6'd14;
    localparam logic [5:0] TRI_REC_BYTES    = 6'd3;
    localparam logic [5:0] TRANS_BYTES      = 6'd48;

    function automatic logic [5:0] hdr_len(input cmd_op_e op);
        case (op)
            OP_VERT:        return VERT_HDR_BYTES;
            OP_TRI:         return TRI_HDR_BYTES;
            OP_CREATE_INST: return CREATE_HDR_BYTES;
            default:        return UPDATE_HDR_BYTES;
        endcase
    endfunction

    function automatic logic [5:0] rec_len(input cmd_op_e op);
        case (op)
            OP_VERT: return VERT_REC_BYTES;
            OP_TRI:  return TRI_REC_BYTES;
            default: return TRANS_BYTES;
        endcase
    endfunction

    // Only vertex and triangle headers carry a record count; instance commands carry one transform.
    function automatic logic has_count(input cmd_op_e op);
        return (op == OP_VERT) || (op == OP_TRI);
    endfunction

endpackage

// File: rtl/vertex_pkg.sv
// Scene geometry widths shared by the upload path and the vertex/triangle stores.
package vertex_pkg;

    localparam int unsigned VTX_W_DEFAULT   = 108;
    localparam int unsigned TRANS_W_DEFAULT = 384;
    localparam int unsigned ADDR_W_DEFAULT  = 13;
    localparam int unsigned TRI_VTX_W       = 24;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Byte-stream decoder for the SPI scene-upload protocol; emits registered field pulses.
module spi_cmd_decoder
    import cmd_pkg::*;
    import vertex_pkg::*;
#(
    parameter int unsigned VTX_W       = VTX_W_DEFAULT,
    parameter int unsigned TRANS_W     = TRANS_W_DEFAULT,
    parameter int unsigned VERT_ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned TRI_ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_sck,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    input  logic                   frame_end,
    output logic                   opcode_valid,
    output logic [3:0]             opcode,
    output logic                   vert_hdr_valid,
    output logic                   vert_valid,
    output logic [7:0]             vert_id,
    output logic [VERT_ADDR_W-1:0] vert_base,
    output logic [7:0]             vert_count,
    output logic [VTX_W-1:0]       vert_in,
    output logic                   tri_hdr_valid,
    output logic                   tri_valid,
    output logic [7:0]             tri_id,
    output logic [TRI_ADDR_W-1:0]  tri_base,
    output logic [7:0]             tri_count,
    output logic [TRI_VTX_W-1:0]   tri_in,
    output logic                   inst_valid,
    output logic [7:0]             inst_id,
    output logic [TRANS_W-1:0]     transform,
    output logic                   create_done,
    output logic                   cmd_err
);

    dec_state_e         state, state_nx;
    cmd_op_e            cur_op, op_byte;
    logic [5:0]         byte_cnt;
    logic [7:0]         rec_cnt, rec_total, hdr_count;
    logic [TRANS_W-1:0] sr, sr_next;
    logic               op_ok, need_hdr, hdr_last, rec_last, last_rec;

    always_comb begin
        sr_next   = (sr << 8) | TRANS_W'(byte_in);
        op_ok     = (byte_in <= OP_MAX);
        op_byte   = cmd_op_e'(byte_in[3:0]);
        need_hdr  = op_ok && (op_byte != OP_WIPE) && (op_byte != OP_DONE);
        hdr_last  = (byte_cnt == hdr_len(cur_op) - 6'd1);
        rec_last  = (byte_cnt == rec_len(cur_op) - 6'd1);
        last_rec  = (rec_cnt == rec_total - 8'd1);
        hdr_count = has_count(cur_op) ? byte_in : 8'd1;

        state_nx = state;
        if (byte_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (!op_ok)
                        state_nx = ST_DRAIN;
                    else if (need_hdr)
                        state_nx = ST_HDR;
                end
                ST_HDR: begin
                    if (hdr_last)
                        state_nx = (hdr_count == 8'd0) ? ST_IDLE : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (rec_last && last_rec)
                        state_nx = ST_IDLE;
                end
                ST_DRAIN: state_nx = ST_DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_sck) begin
        if (rst_sck) begin
            state          <= ST_IDLE;
            cur_op         <= OP_WIPE;
            byte_cnt       <= '0;
            rec_cnt        <= '0;
            rec_total      <= '0;
            sr             <= '0;
            opcode_valid   <= 1'b0;
            opcode         <= '0;
            vert_hdr_valid <= 1'b0;
            vert_valid     <= 1'b0;
            vert_id        <= '0;
            vert_base      <= '0;
            vert_count     <= '0;
            vert_in        <= '0;
            tri_hdr_valid  <= 1'b0;
            tri_valid      <= 1'b0;
            tri_id         <= '0;
            tri_base       <= '0;
            tri_count      <= '0;
            tri_in         <= '0;
            inst_valid     <= 1'b0;
            inst_id        <= '0;
            transform      <= '0;
            create_done    <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            opcode_valid   <= 1'b0;
            vert_hdr_valid <= 1'b0;
            vert_valid     <= 1'b0;
            tri_hdr_valid  <= 1'b0;
            tri_valid      <= 1'b0;
            inst_valid     <= 1'b0;
            state          <= state_nx;

            if (byte_valid) begin
                unique case (state)
                    ST_IDLE: begin
                        byte_cnt <= '0;
                        rec_cnt  <= '0;
                        if (!op_ok) begin
                            cmd_err <= 1'b1;
                        end else if (op_byte == OP_DONE) begin
                            create_done <= 1'b1;
                        end else begin
                            cur_op       <= op_byte;
                            opcode_valid <= 1'b1;
                            opcode       <= byte_in[3:0];
                            create_done  <= 1'b0;
                            if (op_byte == OP_WIPE)
                                cmd_err <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        sr <= sr_next;
                        if (hdr_last) begin
                            byte_cnt  <= '0;
                            rec_cnt   <= '0;
                            rec_total <= hdr_count;
                            case (cur_op)
                                OP_VERT: begin
                                    vert_hdr_valid <= 1'b1;
                                    vert_id        <= sr_next[31:24];
                                    vert_base      <= sr_next[8 +: VERT_ADDR_W];
                                    vert_count     <= sr_next[7:0];
                                end
                                OP_TRI: begin
                                    tri_hdr_valid <= 1'b1;
                                    tri_id        <= sr_next[31:24];
                                    tri_base      <= sr_next[8 +: TRI_ADDR_W];
                                    tri_count     <= sr_next[7:0];
                                end
                                OP_CREATE_INST: begin
                                    inst_id <= sr_next[23:16];
                                    vert_id <= sr_next[15:8];
                                    tri_id  <= sr_next[7:0];
                                end
                                OP_UPDATE_INST: inst_id <= sr_next[7:0];
                                default: ;
                            endcase
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        sr <= sr_next;
                        if (rec_last) begin
                            byte_cnt <= '0;
                            rec_cnt  <= rec_cnt + 8'd1;
                            case (cur_op)
                                OP_VERT: begin
                                    vert_valid <= 1'b1;
                                    vert_in    <= sr_next[VTX_W-1:0];
                                end
                                OP_TRI: begin
                                    tri_valid <= 1'b1;
                                    tri_in    <= sr_next[TRI_VTX_W-1:0];
                                end
                                default: begin
                                    inst_valid <= 1'b1;
                                    transform  <= sr_next;
                                end
                            endcase
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                    ST_DRAIN: ;
                endcase
            end

            // Abort is judged on the post-byte state so a coincident completing byte still counts.
            if (frame_end) begin
                state    <= ST_IDLE;
                byte_cnt <= '0;
                rec_cnt  <= '0;
                if ((state_nx == ST_HDR) || (state_nx == ST_PAYLOAD))
                    cmd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench: stimulus pushes expected pulses into a queue, a negedge monitor pops and compares.
module tb_spi_cmd_decoder;

    localparam int unsigned VTX_W   = 108;
    localparam int unsigned TRANS_W = 384;
    localparam int unsigned VA_W    = 13;
    localparam int unsigned TA_W    = 13;

    localparam int K_OP   = 0;
    localparam int K_VHDR = 1;
    localparam int K_VERT = 2;
    localparam int K_THDR = 3;
    localparam int K_TRI  = 4;
    localparam int K_INST = 5;

    logic               clk = 1'b0;
    logic               rst_sck = 1'b1;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_in = '0;
    logic               frame_end = 1'b0;
    logic               opcode_valid;
    logic [3:0]         opcode;
    logic               vert_hdr_valid, vert_valid;
    logic [7:0]         vert_id, vert_count;
    logic [VA_W-1:0]    vert_base;
    logic [VTX_W-1:0]   vert_in;
    logic               tri_hdr_valid, tri_valid;
    logic [7:0]         tri_id, tri_count;
    logic [TA_W-1:0]    tri_base;
    logic [23:0]        tri_in;
    logic               inst_valid;
    logic [7:0]         inst_id;
    logic [TRANS_W-1:0] transform;
    logic               create_done, cmd_err;

    typedef struct {
        int           kind;
        int unsigned  cyc;
        logic [31:0]  f0, f1, f2;
        logic [383:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    spi_cmd_decoder #(
        .VTX_W(VTX_W), .TRANS_W(TRANS_W), .VERT_ADDR_W(VA_W), .TRI_ADDR_W(TA_W)
    ) dut (
        .clk(clk), .rst_sck(rst_sck), .byte_valid(byte_valid), .byte_in(byte_in),
        .frame_end(frame_end), .opcode_valid(opcode_valid), .opcode(opcode),
        .vert_hdr_valid(vert_hdr_valid), .vert_valid(vert_valid), .vert_id(vert_id),
        .vert_base(vert_base), .vert_count(vert_count), .vert_in(vert_in),
        .tri_hdr_valid(tri_hdr_valid), .tri_valid(tri_valid), .tri_id(tri_id),
        .tri_base(tri_base), .tri_count(tri_count), .tri_in(tri_in),
        .inst_valid(inst_valid), .inst_id(inst_id), .transform(transform),
        .create_done(create_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_OP:    return "opcode_pulse";
            K_VHDR:  return "vert_hdr_pulse";
            K_VERT:  return "vert_pulse";
            K_THDR:  return "tri_hdr_pulse";
            K_TRI:   return "tri_pulse";
            default: return "inst_pulse";
        endcase
    endfunction

    task automatic check_ev(input int k, input logic [31:0] a, b, c, input logic [383:0] d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got unexpected pulse at cycle %0d, required no pulse", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.f0 !== a || e.f1 !== b || e.f2 !== c || e.d !== d) begin
                n_err++;
                $display("FAIL %s: got cyc=%0d f=%0h/%0h/%0h d=%0h, required %s cyc=%0d f=%0h/%0h/%0h d=%0h",
                         kname(k), cyc, a, b, c, d, kname(e.kind), e.cyc, e.f0, e.f1, e.f2, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_sck) begin
            if (opcode_valid)   check_ev(K_OP, 32'(opcode), 32'(create_done), 32'(cmd_err), '0);
            if (vert_hdr_valid) check_ev(K_VHDR, 32'(vert_id), 32'(vert_base), 32'(vert_count), '0);
            if (vert_valid)     check_ev(K_VERT, '0, '0, '0, 384'(vert_in));
            if (tri_hdr_valid)  check_ev(K_THDR, 32'(tri_id), 32'(tri_base), 32'(tri_count), '0);
            if (tri_valid)      check_ev(K_TRI, '0, '0, '0, 384'(tri_in));
            if (inst_valid)     check_ev(K_INST, 32'(inst_id), 32'(vert_id), 32'(tri_id), transform);
        end
    end

    task automatic push(input int k, input logic [31:0] a, b, c, input logic [383:0] d);
        ev_t e;
        e.kind = k; e.cyc = cyc + 1; e.f0 = a; e.f1 = b; e.f2 = c; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1; byte_in = b; frame_end = 1'b0;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_fe(input logic [7:0] b, input logic with_byte);
        byte_valid = with_byte; byte_in = b; frame_end = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; frame_end = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 384'(|{opcode_valid, opcode, vert_hdr_valid, vert_valid, vert_id, vert_base,
                         vert_count, vert_in, tri_hdr_valid, tri_valid, tri_id, tri_base, tri_count,
                         tri_in, inst_valid, inst_id, transform, create_done, cmd_err}), '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst_sck = 1'b0;
        @(posedge clk); #1;

        // Vertex upload: id 5, base 0x0010, two 14-byte records
        push(K_OP, 1, 0, 0, '0);             send(8'h01);
        send(8'h05); send(8'h00); send(8'h10);
        push(K_VHDR, 5, 32'h10, 2, '0);      send(8'h02);
        for (int i = 0; i < 14; i++) begin
            if (i == 13) push(K_VERT, 0, 0, 0, 108'h08182838485868788898A8B8C8D);
            send(8'(8'h80 + i));
        end
        for (int i = 0; i < 14; i++) begin
            if (i == 13) push(K_VERT, 0, 0, 0, 108'h0F1F2F3F4F5F6F7F8F9FAFBFCFD);
            send(8'(8'hF0 + i));
        end

        // Triangle upload: one record AA BB CC
        push(K_OP, 2, 0, 0, '0);             send(8'h02);
        send(8'h07); send(8'h00); send(8'h00);
        push(K_THDR, 7, 0, 1, '0);           send(8'h01);
        send(8'hAA); send(8'hBB);
        push(K_TRI, 0, 0, 0, 24'hAABBCC);    send(8'hCC);

        // Instance creation with a 00..2F transform ramp
        push(K_OP, 3, 0, 0, '0);             send(8'h03);
        send(8'h09); send(8'h05); send(8'h07);
        for (int i = 0; i < 48; i++) begin
            if (i == 47)
                push(K_INST, 9, 5, 7,
                     384'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728292A2B2C2D2E2F);
            send(8'(i));
        end

        // Zero-count header returns to idle; DONE then UPDATE toggles create_done
        push(K_OP, 1, 0, 0, '0);             send(8'h01);
        send(8'h03); send(8'h00); send(8'h20);
        push(K_VHDR, 3, 32'h20, 0, '0);      send(8'h00);
        send(8'h05);
        chk("create_done_set", 384'(create_done), 1);
        push(K_OP, 4, 0, 0, '0);             send(8'h04);
        chk("create_done_cleared", 384'(create_done), 0);
        send_fe(8'h00, 1'b0);
        chk("err_abort_in_hdr", 384'(cmd_err), 1);

        // WIPE clears error; truncated vertex record is aborted without a pulse
        push(K_OP, 0, 0, 0, '0);             send(8'h00);
        chk("err_cleared_by_wipe", 384'(cmd_err), 0);
        push(K_OP, 1, 0, 0, '0);             send(8'h01);
        send(8'h05); send(8'h00); send(8'h10);
        push(K_VHDR, 5, 32'h10, 2, '0);      send(8'h02);
        for (int i = 0; i < 6; i++) send(8'(8'h40 + i));
        send_fe(8'h00, 1'b0);
        chk("err_abort_in_payload", 384'(cmd_err), 1);
        push(K_OP, 0, 0, 0, '0);             send(8'h00);

        // Illegal opcode drains until frame_end
        send(8'h9F);
        chk("err_bad_opcode", 384'(cmd_err), 1);
        send(8'h01); send(8'h02); send(8'h03);
        chk("err_held_in_drain", 384'(cmd_err), 1);
        send_fe(8'h00, 1'b0);
        push(K_OP, 0, 0, 0, '0);             send(8'h00);

        // frame_end together with the completing byte: record kept, no error
        push(K_OP, 2, 0, 0, '0);             send(8'h02);
        send(8'h01); send(8'h00); send(8'h05);
        push(K_THDR, 1, 5, 1, '0);           send(8'h01);
        send(8'h11); send(8'h22);
        push(K_TRI, 0, 0, 0, 24'h112233);    send_fe(8'h33, 1'b1);
        chk("no_err_coincident_end", 384'(cmd_err), 0);
        send(8'h05);
        chk("idle_after_coincident_end", 384'(create_done), 1);

        // Reset mid-payload clears everything at once and emits nothing on release
        push(K_OP, 1, 0, 0, '0);             send(8'h01);
        send(8'h01); send(8'h00); send(8'h00);
        push(K_VHDR, 1, 0, 1, '0);           send(8'h01);
        for (int i = 0; i < 5; i++) send(8'(8'h60 + i));
        chk("transform_before_reset_nonzero", 384'(transform != '0), 1);
        rst_sck = 1'b1;
        #1;
        chk_all_zero("async_reset_outputs");
        chk("async_reset_opcode", 384'(opcode), 0);
        @(posedge clk); #1;
        rst_sck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(K_OP, 0, 0, 0, '0);             send(8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("expected_pulses_outstanding", 384'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameters (name, default, meaning):
- VTX_W, 108, vertex word width.
- TRANS_W, 384, transform width.
- VERT_ADDR_W, 13, vertex RAM address width.
- TRI_ADDR_W, 13, triangle RAM address width.
REQ-002 clk  in  1  byte-domain clock.
REQ-003 rst_sck  in  1  reset, asynchronous, active-high.
REQ-004 byte_valid  in  1  one-cycle strobe; byte_in is valid.
REQ-005 byte_in  in  8  received SPI byte, MSB-first order on the wire.
REQ-006 frame_end  in  1  one-cycle strobe; chip-select deasserted.
REQ-007 opcode_valid  out  1  one-cycle pulse.
REQ-008 opcode  out  4  decoded opcode, held until the next opcode.
REQ-009 vert_hdr_valid, vert_valid  out  1 each  pulses.
REQ-010 vert_id / vert_base / vert_count / vert_in  out  8 / VERT_ADDR_W / 8 / VTX_W  vertex fields.
REQ-011 tri_hdr_valid, tri_valid  out  1 each  pulses.
REQ-012 tri_id / tri_base / tri_count / tri_in  out  8 / TRI_ADDR_W / 8 / 24  triangle fields.
REQ-013 inst_valid  out  1  pulse.
REQ-014 inst_id / transform  out  8 / TRANS_W  instance fields.
REQ-015 create_done  out  1  level; scene upload complete.
REQ-016 cmd_err  out  1  sticky error flag.

Function
REQ-017 Opcode byte: 0x00 WIPE, 0x01 VERT, 0x02 TRI, 0x03 CREATE_INST, 0x04 UPDATE_INST, 0x05 DONE; opcode_valid pulses one cycle after the opcode byte for 0x00-0x04 only.
REQ-018 All multi-byte fields are big-endian; every output field and pulse is registered and appears exactly one cycle after the byte_valid of the completing byte.
REQ-019 VERT: vert_id (1 B), base (2 B, low VERT_ADDR_W bits used), count (1 B) -> vert_hdr_valid; then count records of 14 B each, vert_in = low 108 bits of each record -> one vert_valid per record.
REQ-020 TRI: tri_id (1 B), base (2 B, low TRI_ADDR_W bits used), count (1 B) -> tri_hdr_valid; then count records of 3 B each -> one tri_valid per record, tri_in = {v0,v1,v2}.
REQ-021 CREATE_INST: inst_id, vert_id, tri_id (1 B each), transform (48 B) -> inst_valid with all four fields valid.
REQ-022 UPDATE_INST: inst_id (1 B), transform (48 B) -> inst_valid.
REQ-023 count = 0 returns the block to IDLE immediately after the header pulse.
REQ-024 States: IDLE, HDR, PAYLOAD, DRAIN.
- IDLE -> HDR on an opcode needing a header.
- HDR -> PAYLOAD once the header completes.
- PAYLOAD -> IDLE after the last record.
- WIPE and DONE stay in IDLE.
REQ-025 Byte counter (6 bit) counts within a field or record; record counter (8 bit) counts records.
REQ-026 Shift register is TRANS_W bits wide, shifted left by 8 on every payload byte.
REQ-027 Opcode with upper nibble non-zero, or a value above 0x05: set cmd_err, enter DRAIN, ignore bytes until frame_end.
REQ-028 frame_end in any state: return to IDLE the next cycle and clear the byte and record counters; if the command was incomplete (HDR or PAYLOAD), set cmd_err; no pulse for the partial record.
REQ-029 frame_end and byte_valid in the same cycle: the byte is consumed first, then the abort takes effect.
REQ-030 Bytes after a completed command are parsed as a new opcode; no frame_end is required between commands.
REQ-031 DONE sets create_done; any subsequent opcode 0x00-0x04 clears it in the same cycle that opcode_valid pulses.
REQ-032 cmd_err is cleared only by an opcode byte of 0x00 (WIPE).

Reset
REQ-033 rst_sck asserted: state IDLE, counters 0, shift register 0.
REQ-034 rst_sck asserted: all pulses, create_done, cmd_err, opcode and all field outputs 0.
REQ-035 Reset mid-command discards the command; no pulse is emitted on reset release.

Structure
REQ-036 Opcode enum, per-opcode header and record byte lengths, and the 14 B / 3 B / 48 B constants live in shared package cmd_pkg, imported alongside vertex_pkg.
REQ-037 Single flat module; no sub-module is required.

Verification
REQ-038 Bytes 01,05,00,10,02, then 2x14 B -> opcode_valid with opcode=1; vert_hdr_valid with id=5, base=0x0010, count=2; two vert_valid pulses carrying the records' low 108 bits.
REQ-039 Bytes 02,07,00,00,01,AA,BB,CC -> tri_hdr_valid with id=7, base=0, count=1; tri_valid with tri_in=0xAABBCC one cycle after CC.
REQ-040 Bytes 03,09,05,07, then 48 B ramp 00..2F -> inst_valid with inst_id=9, vert_id=5, tri_id=7, transform=0x000102..2F.
REQ-041 Bytes 01,05,00,10,02, then 6 B, then frame_end -> no vert_valid, cmd_err=1, state IDLE; next byte 00 -> cmd_err=0, opcode_valid pulses.
REQ-042 Byte 05 -> create_done=1; byte 04 -> create_done=0 in the same cycle opcode_valid pulses.
REQ-043 Byte 0x9F -> cmd_err=1, following bytes ignored until frame_end; rst_sck asserted mid-payload -> all outputs 0 immediately.
